imem_boot_ctrl: RTL and testbench
=================================

Name: imem_boot_ctrl

Overview:
Boot/load sequencer for the single-cycle RISC-V instruction memory.
- Holds the CPU in reset and streams a program image, byte by byte, from a loader link such as a UART receiver.
- Assembles little-endian 32-bit words and writes them into instruction memory at word-aligned addresses.
- Once loading completes, releases the CPU and hands the memory address path to CPU fetch.

Parameters:
DATA_WIDTH, 32, instruction word width (fixed at 32 for byte assembly)
ADDR_WIDTH, 32, byte-address width
MEM_SIZE, 512, instruction memory depth in words

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
boot_start  input  1  single-cycle pulse; starts a load (or a direct run)
load_words  input  16  number of words to load; sampled only when boot_start is accepted
boot_abort  input  1  abandons a load in progress
rx_valid  input  1  loader byte valid
rx_data  input  8  loader byte
rx_ready  output  1  controller accepts a byte this cycle
cpu_instr_addr  input  ADDR_WIDTH  CPU fetch byte address
mem_addr  output  ADDR_WIDTH  byte address to instruction memory
mem_wdata  output  DATA_WIDTH  write data to instruction memory
mem_we  output  1  instruction memory write enable
cpu_rst  output  1  holds the CPU in reset while high
busy  output  1  load in progress
done  output  1  CPU running
err  output  1  rejected load request

Behaviour:
- State register is updated on the clk rising edge and cleared asynchronously by reset to HOLD.
- All outputs decode combinationally from state and datapath registers.
- Reset values:
  - cpu_rst=1
  - rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
  - busy=0, done=0, err=0
  - word_idx=0, byte_cnt=0, assembly register=0
- States: HOLD, LOAD, WRITE, RUN, ERR.
- HOLD: cpu_rst=1, rx_ready=0. On boot_start:
  - load_words==0 -> RUN; the preloaded image is kept.
  - load_words>MEM_SIZE -> ERR.
  - Otherwise: latch count, clear word_idx and byte_cnt -> LOAD.
- LOAD: rx_ready=1, busy=1, cpu_rst=1.
  - On rx_valid&&rx_ready, store rx_data into bits [8*byte_cnt+7 : 8*byte_cnt] and increment byte_cnt (2-bit, wraps).
  - The cycle that accepts the 4th byte -> WRITE.
  - rx_valid low: stall with no timeout.
- WRITE: exactly one cycle. mem_we=1, rx_ready=0, busy=1.
  - mem_addr={word_idx,2'b00} (zero-extended); mem_wdata=assembled word.
  - Increment word_idx.
  - If word_idx+1==count -> RUN, else -> LOAD.
- Write throughput: at most 1 word per 5 cycles (4 accept cycles + 1 write cycle).
- RUN: cpu_rst=0, done=1, mem_we=0, mem_addr=cpu_instr_addr (combinational pass-through, zero latency), mem_wdata=0.
- ERR: err=1, cpu_rst=1. Exits only via reset or boot_start, which is evaluated exactly as in HOLD.
- boot_start in RUN or ERR is evaluated as in HOLD. cpu_rst rises in the cycle after acceptance.
- boot_start in LOAD or WRITE is ignored.
- boot_abort:
  - In LOAD: -> HOLD; the partial word is discarded and nothing is written.
  - In WRITE: ignored; the write completes, then the next state is HOLD instead of LOAD/RUN.
  - In other states: ignored.
- boot_start and boot_abort high in the same cycle: boot_abort is applied only in LOAD/WRITE; boot_start follows the rules above in all other states.
- Asynchronous reset mid-load: -> HOLD immediately with mem_we=0. Words already written remain in memory.
- In WRITE, mem_addr is always < MEM_SIZE*4, because count<=MEM_SIZE is guaranteed at acceptance.

Test Plan:
- Reset behaviour: assert reset asynchronously between clock edges -> same cycle: cpu_rst=1, mem_we=0, rx_ready=0, done=0, err=0, busy=0.
- Two-word load: boot_start with load_words=2, bytes 13 00 00 00 93 00 10 00 -> mem_we pulses twice: 0x00000013 at addr 0x0, then 0x00100093 at addr 0x4. Next cycle: done=1, cpu_rst=0, and mem_addr tracks cpu_instr_addr=0x8.
- Direct run and rejected load:
  - load_words=0 -> RUN one cycle after boot_start, with no writes.
  - load_words=513 -> err=1 with cpu_rst held; a subsequent boot_start with load_words=1 proceeds to LOAD.
- Stall handling: rx_valid gaps of 0-7 cycles between bytes of a 3-word load -> correct words written at addrs 0x0/0x4/0x8, and rx_ready never drops in LOAD.
- Abort and mid-load reset:
  - boot_abort after 2 bytes -> HOLD, with no mem_we.
  - Async reset during the 2nd word -> HOLD; word 0 stays written.
- Reload from RUN: boot_start in RUN with load_words=1 -> cpu_rst=1 next cycle; reload completes, then done=1.

Source files
------------

// File: rtl/imem_boot_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_boot_ctrl_if
// Groups the boot-controller signals: start/abort control, the byte-wide
// loader link, the instruction-memory write/address path and the status flags.
//   master : the boot controller (drives rx_ready, mem_*, cpu_rst, status)
//   slave  : the environment (loader, CPU fetch port, boot host)
// -----------------------------------------------------------------------------
interface imem_boot_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  boot_start;
  logic [15:0]           load_words;
  logic                  boot_abort;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] cpu_instr_addr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  cpu_rst;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  boot_start, load_words, boot_abort, rx_valid, rx_data, cpu_instr_addr,
    output rx_ready, mem_addr, mem_wdata, mem_we, cpu_rst, busy, done, err
  );

  modport slave (
    output boot_start, load_words, boot_abort, rx_valid, rx_data, cpu_instr_addr,
    input  rx_ready, mem_addr, mem_wdata, mem_we, cpu_rst, busy, done, err
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// -----------------------------------------------------------------------------
// imem_boot_ctrl
// Boot/load sequencer for the instruction memory. Holds the CPU in reset,
// takes a program image byte by byte from the loader link, assembles
// little-endian words and writes them to consecutive word addresses. After
// the last word it releases the CPU and passes CPU fetch addresses straight
// through to the memory.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (returns to HOLD)
//   bus   : imem_boot_ctrl_if.master
//           boot_start/load_words/boot_abort : load control
//           rx_valid/rx_data/rx_ready        : loader byte handshake
//           cpu_instr_addr                   : CPU fetch byte address
//           mem_addr/mem_wdata/mem_we        : instruction memory port
//           cpu_rst/busy/done/err            : status
// -----------------------------------------------------------------------------
module imem_boot_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 512
) (
  input  logic                clk,
  input  logic                reset,
  imem_boot_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // One bit wider than load_words so the size compare cannot overflow.
  localparam logic [16:0] MEM_SIZE_W = 17'(MEM_SIZE);

  state_t                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;

  logic [17:0]           write_addr;

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    unique case (state_q)
      // HOLD, RUN and ERR all treat boot_start the same way.
      S_HOLD, S_RUN, S_ERR: begin
        if (bus.boot_start) begin
          if (bus.load_words == 16'd0) begin
            state_d = S_RUN;
          end else if ({1'b0, bus.load_words} > MEM_SIZE_W) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_LOAD;
            count_d    = bus.load_words;
            word_idx_d = '0;
            byte_cnt_d = '0;
            asm_d      = '0;
          end
        end
      end
      S_LOAD: begin
        if (bus.boot_abort) begin
          // Partial word is dropped; nothing reaches memory.
          state_d    = S_HOLD;
          byte_cnt_d = '0;
          asm_d      = '0;
        end else if (bus.rx_valid) begin
          asm_d[8*byte_cnt_q +: 8] = bus.rx_data;
          byte_cnt_d               = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // The write always completes; abort only redirects the exit.
        word_idx_d = word_idx_q + 16'd1;
        if (bus.boot_abort) begin
          state_d = S_HOLD;
        end else if (word_idx_d == count_q) begin
          state_d = S_RUN;
        end else begin
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_HOLD;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
    end
  end

  assign write_addr = {word_idx_q, 2'b00};

  // Output decode from state and datapath registers
  always_comb begin
    bus.rx_ready  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.cpu_rst   = 1'b1;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        bus.rx_ready = 1'b1;
        bus.busy     = 1'b1;
      end
      S_WRITE: begin
        bus.mem_we    = 1'b1;
        bus.busy      = 1'b1;
        bus.mem_addr  = ADDR_WIDTH'(write_addr);
        bus.mem_wdata = asm_q;
      end
      S_RUN: begin
        // Zero-latency fetch path once the CPU is running.
        bus.cpu_rst  = 1'b0;
        bus.done     = 1'b1;
        bus.mem_addr = bus.cpu_instr_addr;
      end
      S_ERR: begin
        bus.err = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_ctrl
// Randomized bench for imem_boot_ctrl. The reference model is the program
// image itself: each expected word is the little-endian sum of its bytes and
// lands at byte address 4*index. A monitor plays the instruction memory.
// -----------------------------------------------------------------------------
module tb_imem_boot_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_boot_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();

  imem_boot_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MEM_SIZE  (512)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  int total  = 0;
  int bad    = 0;
  int wr_cnt = 0;

  logic [31:0] imem     [512];
  logic [31:0] exp_imem [512];
  logic [7:0]  bytes    [16][4];

  // Instruction memory stand-in: capture every write.
  always @(negedge clk) begin
    if (bif.mem_we === 1'b1) begin
      wr_cnt++;
      if (bif.mem_addr < 32'd2048) imem[bif.mem_addr[10:2]] = bif.mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int w);
    return 32'(bytes[w][0]) + 32'(bytes[w][1]) * 32'd256 +
           32'(bytes[w][2]) * 32'd65536 + 32'(bytes[w][3]) * 32'd16777216;
  endfunction

  task automatic set_word(input int w, input logic [31:0] v);
    for (int b = 0; b < 4; b++) bytes[w][b] = 8'((v / (32'd1 << (8 * b))) % 32'd256);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int n);
    bif.boot_start = 1'b1;
    bif.load_words = 16'(n);
    tick();
    bif.boot_start = 1'b0;
    bif.load_words = 16'($urandom);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_cpu_rst", 32'(bif.cpu_rst), 32'd1);
    chk("rst_we",      32'(bif.mem_we), 32'd0);
    chk("rst_rdy",     32'(bif.rx_ready), 32'd0);
    chk("rst_done",    32'(bif.done), 32'd0);
    chk("rst_err",     32'(bif.err), 32'd0);
    chk("rst_busy",    32'(bif.busy), 32'd0);
    chk("rst_addr",    bif.mem_addr, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
  endtask

  // Stall a random number of cycles (optionally poking boot_start, which
  // must be ignored while loading), then present one byte.
  task automatic send_byte(input logic [7:0] b, input int gapmax, input bit noise);
    int g;
    g = $urandom_range(gapmax, 0);
    for (int i = 0; i < g; i++) begin
      if (noise) begin
        bif.boot_start = ($urandom_range(3, 0) == 0);
        bif.load_words = 16'd0;
      end
      @(negedge clk);
      chk("rdy_gap", 32'(bif.rx_ready), 32'd1);
      tick();
      bif.boot_start = 1'b0;
    end
    bif.rx_valid = 1'b1;
    bif.rx_data  = b;
    @(negedge clk);
    chk("rdy_byte", 32'(bif.rx_ready), 32'd1);
    tick();
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'($urandom);
  endtask

  task automatic send_word(input int w, input int gapmax, input bit noise, input bit abort_wr);
    for (int b = 0; b < 4; b++) send_byte(bytes[w][b], gapmax, noise);
    bif.boot_abort = abort_wr;
    @(negedge clk);
    chk("we",    32'(bif.mem_we), 32'd1);
    chk("waddr", bif.mem_addr, 32'(w * 4));
    chk("wdata", bif.mem_wdata, word_of(w));
    exp_imem[w] = word_of(w);
    tick();
    bif.boot_abort = 1'b0;
  endtask

  task automatic xfer(input int n, input int gapmax, input bit noise);
    logic [31:0] a;
    for (int w = 0; w < n; w++) send_word(w, gapmax, noise, 1'b0);
    @(negedge clk);
    chk("run_done",    32'(bif.done), 32'd1);
    chk("run_cpu_rst", 32'(bif.cpu_rst), 32'd0);
    chk("run_busy",    32'(bif.busy), 32'd0);
    a = $urandom;
    bif.cpu_instr_addr = a;
    #1;
    chk("run_pass", bif.mem_addr, a);
  endtask

  initial begin
    int c;
    int n;
    bif.boot_start     = 1'b0;
    bif.load_words     = 16'd0;
    bif.boot_abort     = 1'b0;
    bif.rx_valid       = 1'b0;
    bif.rx_data        = 8'd0;
    bif.cpu_instr_addr = 32'd0;
    for (int i = 0; i < 512; i++) begin
      imem[i]     = 32'd0;
      exp_imem[i] = 32'd0;
    end

    // Power-on reset state
    #2;
    chk("por_cpu_rst", 32'(bif.cpu_rst), 32'd1);
    chk("por_rdy",     32'(bif.rx_ready), 32'd0);
    chk("por_wdata",   bif.mem_wdata, 32'd0);
    tick();
    reset = 1'b0;
    async_reset();

    // Directed two-word image
    set_word(0, 32'h0000_0013);
    set_word(1, 32'h0010_0093);
    start(2);
    xfer(2, 0, 1'b0);
    bif.cpu_instr_addr = 32'h8;
    #1;
    chk("pass8", bif.mem_addr, 32'h8);

    // Reload from RUN
    set_word(0, $urandom);
    start(1);
    chk("reload_rst",  32'(bif.cpu_rst), 32'd1);
    chk("reload_busy", 32'(bif.busy), 32'd1);
    xfer(1, 2, 1'b0);

    // Direct run
    async_reset();
    c = wr_cnt;
    start(0);
    chk("direct_done", 32'(bif.done), 32'd1);
    chk("direct_rst",  32'(bif.cpu_rst), 32'd0);
    repeat (3) tick();
    chk("direct_nowr", 32'(wr_cnt), 32'(c));

    // Oversized request from RUN, then a valid one from ERR
    start(513);
    chk("rej_err",  32'(bif.err), 32'd1);
    chk("rej_rst",  32'(bif.cpu_rst), 32'd1);
    chk("rej_done", 32'(bif.done), 32'd0);
    chk("rej_busy", 32'(bif.busy), 32'd0);
    set_word(0, $urandom);
    start(1);
    chk("err_exit_busy", 32'(bif.busy), 32'd1);
    chk("err_exit_err",  32'(bif.err), 32'd0);
    xfer(1, 3, 1'b0);

    // Largest legal count is accepted; abort it right away
    start(512);
    chk("max_busy", 32'(bif.busy), 32'd1);
    bif.boot_abort = 1'b1;
    tick();
    bif.boot_abort = 1'b0;
    chk("max_abort_busy", 32'(bif.busy), 32'd0);

    // Stalled three-word load
    async_reset();
    for (int w = 0; w < 3; w++) set_word(w, $urandom);
    start(3);
    xfer(3, 7, 1'b1);

    // Abort after two bytes
    async_reset();
    c = wr_cnt;
    start(2);
    send_byte(8'($urandom), 2, 1'b0);
    send_byte(8'($urandom), 2, 1'b0);
    bif.boot_abort = 1'b1;
    tick();
    bif.boot_abort = 1'b0;
    chk("abort_busy", 32'(bif.busy), 32'd0);
    chk("abort_rdy",  32'(bif.rx_ready), 32'd0);
    chk("abort_rst",  32'(bif.cpu_rst), 32'd1);
    repeat (5) tick();
    chk("abort_nowr", 32'(wr_cnt), 32'(c));

    // Abort during the write cycle: the write lands, then HOLD
    set_word(0, $urandom);
    start(2);
    send_word(0, 1, 1'b0, 1'b1);
    chk("abwr_busy", 32'(bif.busy), 32'd0);
    chk("abwr_done", 32'(bif.done), 32'd0);
    chk("abwr_rdy",  32'(bif.rx_ready), 32'd0);

    // Asynchronous reset in the middle of the second word
    set_word(0, $urandom);
    set_word(1, $urandom);
    c = wr_cnt;
    start(2);
    send_word(0, 1, 1'b0, 1'b0);
    send_byte(bytes[1][0], 1, 1'b0);
    send_byte(bytes[1][1], 1, 1'b0);
    async_reset();
    chk("mid_rst_wr",   32'(wr_cnt), 32'(c + 1));
    chk("mid_rst_keep", imem[0], word_of(0));
    chk("mid_rst_busy", 32'(bif.busy), 32'd0);

    // Random images, some loaded from RUN, some from HOLD
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(1, 0) == 1) async_reset();
      n = $urandom_range(6, 1);
      for (int w = 0; w < n; w++) set_word(w, $urandom);
      start(n);
      xfer(n, 3, 1'b1);
    end

    // Memory image must match every word the model says was written
    for (int i = 0; i < 8; i++) chk($sformatf("image%0d", i), imem[i], exp_imem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
